serpent_subkey_store: RTL and testbench

Subkey buffer directly downstream of the Serpent `key_schedule` block. It captures the 33 × 128-bit round subkeys as the key schedule emits them (subkey, address, valid). It tracks which entries have been written and raises a ready flag once the full set is present. It serves subkeys to the bitsliced round core through a one-cycle-latency read port.

---
 rtl/serpent_subkey_store.sv | 105 ++++++++++
 tb/tb_serpent_subkey_store.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serpent_subkey_store.sv
// Subkey buffer for the Serpent round core: captures the 33 round subkeys from
// the key schedule, tracks which entries are present and serves them with one-cycle read latency.
module serpent_subkey_store #(
   parameter int NUM_SUBKEYS = 33,
   parameter int WIDTH       = 128,
   parameter int AW          = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_subkey,
   input  logic [AW-1:0]    i_address,
   input  logic             i_subkey_valid,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_subkey,
   output logic             o_rd_valid,
   output logic             o_rd_miss,
   output logic             o_ready,
   output logic [AW-1:0]    o_count,
   output logic             o_addr_err
);

   localparam logic [AW-1:0]          NUM_A   = AW'(NUM_SUBKEYS);
   localparam logic [NUM_SUBKEYS-1:0] ONE_HOT = {{(NUM_SUBKEYS-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]       subkey_mem [NUM_SUBKEYS];
   logic [NUM_SUBKEYS-1:0] bitmap_q, bitmap_d;
   logic [AW-1:0]          count_q, count_d;
   logic                   ready_q, ready_d;
   logic                   addr_err_q, addr_err_d;
   logic [WIDTH-1:0]       rd_subkey_q, rd_subkey_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   rd_miss_q, rd_miss_d;

   logic [NUM_SUBKEYS-1:0] wr_mask, rd_mask;
   logic                   wr_in_range, rd_in_range, wr_en, wr_new, rd_hit;

   always_comb begin
      // Shifting past the top bit yields an empty mask for out-of-range indices.
      wr_mask     = ONE_HOT << i_address;
      rd_mask     = ONE_HOT << i_rd_addr;
      wr_in_range = (i_address < NUM_A);
      rd_in_range = (i_rd_addr < NUM_A);
      wr_en       = i_subkey_valid & wr_in_range & ~i_clear & ~i_rst;
      wr_new      = wr_en & ~(|(bitmap_q & wr_mask));
      rd_hit      = rd_in_range & (|(bitmap_q & rd_mask));
   end

   always_comb begin
      bitmap_d   = bitmap_q;
      count_d    = count_q;
      addr_err_d = addr_err_q;
      if (i_clear) begin
         bitmap_d   = '0;
         count_d    = '0;
         addr_err_d = 1'b0;
      end else begin
         if (wr_en) bitmap_d = bitmap_q | wr_mask;
         if (wr_new) count_d = count_q + 1'b1;
         if (i_subkey_valid && !wr_in_range) addr_err_d = 1'b1;
      end
      ready_d = (count_d == NUM_A);
   end

   // Read uses pre-edge bitmap and memory contents, giving read-first behaviour.
   always_comb begin
      rd_valid_d  = i_rd_en;
      rd_miss_d   = i_rd_en & ~rd_hit;
      rd_subkey_d = rd_subkey_q;
      if (i_rd_en) rd_subkey_d = rd_hit ? subkey_mem[i_rd_addr] : '0;
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) subkey_mem[i_address] <= i_subkey;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bitmap_q    <= '0;
         count_q     <= '0;
         ready_q     <= 1'b0;
         addr_err_q  <= 1'b0;
         rd_subkey_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_miss_q   <= 1'b0;
      end else begin
         bitmap_q    <= bitmap_d;
         count_q     <= count_d;
         ready_q     <= ready_d;
         addr_err_q  <= addr_err_d;
         rd_subkey_q <= rd_subkey_d;
         rd_valid_q  <= rd_valid_d;
         rd_miss_q   <= rd_miss_d;
      end
   end

   assign o_rd_subkey = rd_subkey_q;
   assign o_rd_valid  = rd_valid_q;
   assign o_rd_miss   = rd_miss_q;
   assign o_ready     = ready_q;
   assign o_count     = count_q;
   assign o_addr_err  = addr_err_q;

endmodule

// File: tb/tb_serpent_subkey_store.sv
// Directed bench for serpent_subkey_store: load/clear/collision vectors from a table
// plus hand-written load loops and an asynchronous reset sequence.
module tb_serpent_subkey_store;

   logic         clk = 1'b0;
   logic         rst;
   logic         clear;
   logic [127:0] subkey;
   logic [5:0]   address;
   logic         subkey_valid;
   logic         rd_en;
   logic [5:0]   rd_addr;
   logic [127:0] rd_subkey;
   logic         rd_valid;
   logic         rd_miss;
   logic         ready;
   logic [5:0]   count;
   logic         addr_err;

   int tests = 0;
   int fails = 0;

   serpent_subkey_store dut (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_subkey(subkey),
      .i_address(address), .i_subkey_valid(subkey_valid), .i_rd_en(rd_en),
      .i_rd_addr(rd_addr), .o_rd_subkey(rd_subkey), .o_rd_valid(rd_valid),
      .o_rd_miss(rd_miss), .o_ready(ready), .o_count(count), .o_addr_err(addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         clr;
      logic         wr;
      logic [5:0]   wa;
      logic [127:0] wd;
      logic         rd;
      logic [5:0]   ra;
      logic         e_valid;
      logic         e_miss;
      logic [127:0] e_data;
      logic [5:0]   e_count;
      logic         e_ready;
      logic         e_err;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [127:0] kval(input int k);
      logic [31:0] w;
      w = 32'(k);
      return {4{w}};
   endfunction

   function automatic vec_t mk(input logic clr, input logic wr, input logic [5:0] wa,
                               input logic [127:0] wd, input logic rd, input logic [5:0] ra,
                               input logic ev, input logic em, input logic [127:0] ed,
                               input logic [5:0] ec, input logic er, input logic ee);
      vec_t v;
      v.clr = clr; v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
      v.e_valid = ev; v.e_miss = em; v.e_data = ed; v.e_count = ec; v.e_ready = er; v.e_err = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clear = 1'b0; subkey_valid = 1'b0; rd_en = 1'b0;
      subkey = '0; address = '0; rd_addr = '0;
   endtask

   task automatic write_one(input int a, input logic [127:0] d);
      idle_inputs();
      subkey_valid = 1'b1; address = 6'(a); subkey = d;
      tick();
      idle_inputs();
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      string n;
      v = vecs[idx];
      clear = v.clr; subkey_valid = v.wr; address = v.wa; subkey = v.wd;
      rd_en = v.rd; rd_addr = v.ra;
      tick();
      idle_inputs();
      n = $sformatf("vec%0d", idx);
      check({n, ".rd_valid"}, 128'(rd_valid), 128'(v.e_valid));
      check({n, ".rd_miss"},  128'(rd_miss),  128'(v.e_miss));
      check({n, ".rd_data"},  rd_subkey,      v.e_data);
      check({n, ".count"},    128'(count),    128'(v.e_count));
      check({n, ".ready"},    128'(ready),    128'(v.e_ready));
      check({n, ".addr_err"}, 128'(addr_err), 128'(v.e_err));
   endtask

   initial begin
      // Vectors 0..12 follow a full load of K0..K32; 13..16 follow a partial load of 0..31.
      vecs[0]  = mk(0, 0, 0, '0, 1, 5,   1, 0, kval(5), 33, 1, 0);
      vecs[1]  = mk(0, 0, 0, '0, 0, 0,   0, 0, kval(5), 33, 1, 0);
      vecs[2]  = mk(0, 1, 3, {32{4'hA}}, 1, 3, 1, 0, kval(3), 33, 1, 0);
      vecs[3]  = mk(0, 0, 0, '0, 1, 3,   1, 0, {32{4'hA}}, 33, 1, 0);
      vecs[4]  = mk(0, 1, 7, {32{4'h1}}, 0, 0, 0, 0, {32{4'hA}}, 33, 1, 0);
      vecs[5]  = mk(0, 1, 7, {32{4'h2}}, 1, 7, 1, 0, {32{4'h1}}, 33, 1, 0);
      vecs[6]  = mk(0, 0, 0, '0, 1, 7,   1, 0, {32{4'h2}}, 33, 1, 0);
      vecs[7]  = mk(0, 1, 40, {32{4'h5}}, 0, 0, 0, 0, {32{4'h2}}, 33, 1, 1);
      vecs[8]  = mk(0, 0, 0, '0, 1, 40,  1, 1, '0, 33, 1, 1);
      vecs[9]  = mk(1, 0, 0, '0, 1, 1,   1, 0, kval(1), 0, 0, 0);
      vecs[10] = mk(0, 0, 0, '0, 1, 0,   1, 1, '0, 0, 0, 0);
      vecs[11] = mk(1, 1, 0, {32{4'h3}}, 0, 0, 0, 0, '0, 0, 0, 0);
      vecs[12] = mk(0, 0, 0, '0, 1, 0,   1, 1, '0, 0, 0, 0);
      vecs[13] = mk(0, 0, 0, '0, 1, 32,  1, 1, '0, 32, 0, 0);
      vecs[14] = mk(0, 0, 0, '0, 1, 31,  1, 0, kval(31), 32, 0, 0);
      vecs[15] = mk(0, 1, 7, {32{4'h4}}, 0, 0, 0, 0, kval(31), 32, 0, 0);
      vecs[16] = mk(0, 0, 0, '0, 1, 7,   1, 0, {32{4'h4}}, 32, 0, 0);

      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check("reset.rd_data",  rd_subkey,         '0);
      check("reset.rd_valid", 128'(rd_valid),    '0);
      check("reset.rd_miss",  128'(rd_miss),     '0);
      check("reset.ready",    128'(ready),       '0);
      check("reset.count",    128'(count),       '0);
      check("reset.addr_err", 128'(addr_err),    '0);

      for (int k = 0; k < 33; k++) begin
         write_one(k, kval(k));
         check($sformatf("load.count%0d", k), 128'(count), 128'(k + 1));
         check($sformatf("load.ready%0d", k), 128'(ready), 128'(k == 32));
      end
      for (int i = 0; i <= 12; i++) run_vec(i);

      // Partial load after the clear/write collision left the store empty.
      for (int k = 0; k < 32; k++) begin
         write_one(k, kval(k));
         check($sformatf("part.count%0d", k), 128'(count), 128'(k + 1));
         check($sformatf("part.ready%0d", k), 128'(ready), 128'(0));
      end
      for (int i = 13; i <= 16; i++) run_vec(i);

      // Reset mid-operation: clear, load 10 entries, make outputs non-zero, then reset between edges.
      clear = 1'b1;
      tick();
      idle_inputs();
      for (int k = 0; k < 10; k++) write_one(k, kval(k + 100));
      rd_en = 1'b1; rd_addr = 6'd3;
      tick();
      idle_inputs();
      check("pre_rst.rd_data", rd_subkey, kval(103));
      check("pre_rst.count", 128'(count), 128'(10));
      subkey_valid = 1'b1; address = 6'd10; subkey = {32{4'hF}};
      rd_en = 1'b1; rd_addr = 6'd4;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst.rd_data",  rd_subkey,      '0);
      check("async_rst.rd_valid", 128'(rd_valid), '0);
      check("async_rst.count",    128'(count),    '0);
      check("async_rst.ready",    128'(ready),    '0);
      @(posedge clk);
      #1;
      check("in_rst.count", 128'(count), '0);
      check("in_rst.rd_valid", 128'(rd_valid), '0);
      idle_inputs();
      rst = 1'b0;
      tick();
      for (int k = 0; k < 11; k++) begin
         rd_en = 1'b1; rd_addr = 6'(k);
         tick();
         idle_inputs();
         check($sformatf("post_rst.miss%0d", k),  128'(rd_miss),  128'(1));
         check($sformatf("post_rst.valid%0d", k), 128'(rd_valid), 128'(1));
         check($sformatf("post_rst.data%0d", k),  rd_subkey,      '0);
      end
      check("post_rst.count", 128'(count), '0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
